// File: rtl/wsp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : wsp_pkg                                                        |
// | Purpose   : Shared definitions for the IEEE 1500 wrapper instruction       |
// |             register: default opcode width, opcode enumeration and the     |
// |             default WIR capture value.                                     |
// | Ports     : none (package)                                                 |
// | Options   : WIR_CLAMP_EN - enables opcode 5 as WS_CLAMP in the decoder     |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
package wsp_pkg;

  // Default WIR opcode width. Three is the minimum that holds every opcode.
  localparam int DEF_IR_W = 3;

  // Default value loaded into the WIR shift stage on capture.
  localparam logic [2:0] DEF_CAPTURE_VAL = 3'b001;

  // Wrapper instruction opcodes. Unlisted values decode as WS_BYPASS.
  typedef enum logic [2:0] {
    WS_BYPASS  = 3'd0,
    WS_EXTEST  = 3'd1,
    WS_INTEST  = 3'd2,
    WS_SAFE    = 3'd3,
    WS_PRELOAD = 3'd4,
    WS_CLAMP   = 3'd5
  } wir_op_e;

endpackage : wsp_pkg
`default_nettype wire

// File: rtl/wir_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : wir_decoder                                                    |
// | Purpose   : Combinational decode of a WIR opcode into the boundary-chain   |
// |             control set.                                                   |
// | Ports     : op_i         - opcode to decode                                |
// |             sel_o        - 1: data path goes through the WBR, 0: WBY       |
// |             mode_o       - boundary cells drive from update stage / safe   |
// |             safe_o       - boundary cells force their safe value           |
// |             capture_ok_o - boundary-cell capture permitted                 |
// | Options   : WIR_CLAMP_EN - opcode 5 decodes as WS_CLAMP (mode=1, WBY sel); |
// |             when undefined opcode 5 decodes as WS_BYPASS                   |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module wir_decoder
  import wsp_pkg::*;
#(
  parameter int IR_W = DEF_IR_W
) (
  input  logic [IR_W-1:0] op_i,
  output logic            sel_o,
  output logic            mode_o,
  output logic            safe_o,
  output logic            capture_ok_o
);

  always_comb begin
    sel_o        = 1'b0;
    mode_o       = 1'b0;
    safe_o       = 1'b0;
    capture_ok_o = 1'b1;
    case (op_i)
      IR_W'(WS_EXTEST): begin
        sel_o  = 1'b1;
        mode_o = 1'b1;
      end
      IR_W'(WS_INTEST): begin
        sel_o  = 1'b1;
        mode_o = 1'b1;
      end
      IR_W'(WS_SAFE): begin
        mode_o = 1'b1;
        safe_o = 1'b1;
      end
      // PRELOAD loads the chain without disturbing functional mode, and
      // must not overwrite the shifted-in values with captured data.
      IR_W'(WS_PRELOAD): begin
        sel_o        = 1'b1;
        capture_ok_o = 1'b0;
      end
`ifdef WIR_CLAMP_EN
      IR_W'(WS_CLAMP): begin
        mode_o = 1'b1;
      end
`endif
      default: begin
        // WS_BYPASS and every unassigned opcode
      end
    endcase
  end

endmodule : wir_decoder
`default_nettype wire

// File: rtl/wir_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : wir_ctrl                                                       |
// | Purpose   : IEEE 1500 Wrapper Instruction Register with wrapper bypass     |
// |             register and boundary-cell control generation.                 |
// | Ports     : clk, arst_n               - WRCK, async active-low reset       |
// |             wsi, selectwir, shiftwr,  - Wrapper Serial Port inputs         |
// |             capturewr, updatewr                                            |
// |             wbr_so                    - scan-out of last boundary cell     |
// |             wso                       - wrapper serial output              |
// |             wbr_shift/capture/update  - gated boundary-cell strobes        |
// |             wbr_mode, wbr_safe        - registered cell mode controls      |
// |             active_op                 - current updated instruction        |
// |             wsp_err                   - sticky shift+capture conflict      |
// | Options   : WIR_CLAMP_EN - enables WS_CLAMP (opcode 5), see wir_decoder    |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module wir_ctrl
  import wsp_pkg::*;
#(
  parameter int              IR_W        = DEF_IR_W,   // must be >= 3
  parameter logic [IR_W-1:0] CAPTURE_VAL = IR_W'(DEF_CAPTURE_VAL)
) (
  input  logic            clk,
  input  logic            arst_n,
  input  logic            wsi,
  input  logic            selectwir,
  input  logic            shiftwr,
  input  logic            capturewr,
  input  logic            updatewr,
  input  logic            wbr_so,
  output logic            wso,
  output logic            wbr_shift,
  output logic            wbr_capture,
  output logic            wbr_update,
  output logic            wbr_mode,
  output logic            wbr_safe,
  output logic [IR_W-1:0] active_op,
  output logic            wsp_err
);

  logic [IR_W-1:0] wir_sr_q, wir_sr_d;
  logic [IR_W-1:0] active_op_q, active_op_d;
  logic            mode_q, safe_q, sel_q, cap_ok_q;
  logic            mode_d, safe_d, sel_d, cap_ok_d;
  logic            wby_q, wby_d;
  logic            err_q, err_d;

  // WIR shift stage: capture beats shift, LSB leaves first.
  always_comb begin
    wir_sr_d = wir_sr_q;
    if (selectwir) begin
      if (capturewr) begin
        wir_sr_d = CAPTURE_VAL;
      end else if (shiftwr) begin
        wir_sr_d = {wsi, wir_sr_q[IR_W-1:1]};
      end
    end
  end

  // Update samples the pre-shift stage, so a simultaneous shift does not
  // leak its new bit into the instruction.
  assign active_op_d = (selectwir && updatewr) ? wir_sr_q : active_op_q;

  // Decode the next instruction so that the control registers change on the
  // same edge as active_op and never glitch.
  wir_decoder #(
    .IR_W (IR_W)
  ) u_decoder (
    .op_i         (active_op_d),
    .sel_o        (sel_d),
    .mode_o       (mode_d),
    .safe_o       (safe_d),
    .capture_ok_o (cap_ok_d)
  );

  // Wrapper bypass register, only active when it owns the data path.
  always_comb begin
    wby_d = wby_q;
    if (!selectwir && !sel_q) begin
      if (capturewr) begin
        wby_d = 1'b0;
      end else if (shiftwr) begin
        wby_d = wsi;
      end
    end
  end

  assign err_d = err_q | (shiftwr & capturewr);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wir_sr_q    <= '0;
      active_op_q <= IR_W'(WS_BYPASS);
      mode_q      <= 1'b0;
      safe_q      <= 1'b0;
      sel_q       <= 1'b0;
      cap_ok_q    <= 1'b1;
      wby_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      wir_sr_q    <= wir_sr_d;
      active_op_q <= active_op_d;
      mode_q      <= mode_d;
      safe_q      <= safe_d;
      sel_q       <= sel_d;
      cap_ok_q    <= cap_ok_d;
      wby_q       <= wby_d;
      err_q       <= err_d;
    end
  end

  // Strobes only reach the cells when the WBR owns the data path.
  assign wbr_shift   = shiftwr & ~capturewr & ~selectwir & sel_q;
  assign wbr_capture = capturewr & ~selectwir & sel_q & cap_ok_q;
  assign wbr_update  = updatewr & ~selectwir & sel_q;

  assign wso       = selectwir ? wir_sr_q[0] : (sel_q ? wbr_so : wby_q);
  assign wbr_mode  = mode_q;
  assign wbr_safe  = safe_q;
  assign active_op = active_op_q;
  assign wsp_err   = err_q;

endmodule : wir_ctrl
`default_nettype wire

// File: doc/wir_ctrl.md
Name: wir_ctrl

Overview:
- IEEE 1500 Wrapper Instruction Register (WIR) plus wrapper-control decoder.
- Sits between the Wrapper Serial Port (WSP) and the boundary-cell chain, directly upstream of every wrapper boundary cell.
- Shifts and updates the instruction, holds a 1-bit wrapper bypass register (WBY), and generates the cells' shift/capture/update/mode/safe controls.
- Muxes WSO from the WIR, WBY, or the WBR scan-out.

Parameters:
- IR_W, 3, WIR opcode width (minimum 3).
- CAPTURE_VAL, 3'b001, value loaded into the WIR shift stage on capturewr with selectwir=1. Bits beyond bit 0 are zero when IR_W>3.

Ports:
- clk  in  1  wrapper clock (WRCK); all state on posedge
- arst_n  in  1  asynchronous active-low reset
- wsi  in  1  wrapper serial input
- selectwir  in  1  1 = WIR path, 0 = data path (WBR/WBY)
- shiftwr  in  1  WSP shift enable
- capturewr  in  1  WSP capture enable
- updatewr  in  1  WSP update enable
- wbr_so  in  1  serial out of last boundary cell
- wso  out  1  wrapper serial output
- wbr_shift  out  1  boundary-cell shift
- wbr_capture  out  1  boundary-cell capture
- wbr_update  out  1  boundary-cell update
- wbr_mode  out  1  cells drive from update stage / safe
- wbr_safe  out  1  cells force safe value
- active_op  out  IR_W  current updated instruction
- wsp_err  out  1  sticky: shiftwr and capturewr seen high together

Behaviour:
- Opcodes: 0 WS_BYPASS, 1 WS_EXTEST, 2 WS_INTEST, 3 WS_SAFE, 4 WS_PRELOAD, 5 WS_CLAMP (see optional feature). Any other value decodes as WS_BYPASS.
- Reset: wir_sr=0, active_op=WS_BYPASS, wby=0, wbr_mode=0, wbr_safe=0, wsp_err=0. Gated outputs are therefore 0 and wso=0.
- WIR shift stage, when selectwir=1:
  - capturewr -> load CAPTURE_VAL.
  - else shiftwr -> {wsi, wir_sr[IR_W-1:1]}, LSB out first.
  - else hold.
- WIR update, when selectwir=1 and updatewr=1: active_op <= wir_sr at the posedge. Shift and update in the same cycle: update takes pre-shift wir_sr and the shift also occurs.
- Registered decode: wbr_mode and wbr_safe register from the decode of the next active_op, so they are valid together with active_op and glitch-free.
  - wbr_mode=1 for EXTEST, INTEST, SAFE, CLAMP.
  - wbr_safe=1 for SAFE only.
  - PRELOAD and BYPASS give mode=0.
- Data-path select: wbr_sel=1 for EXTEST, INTEST, PRELOAD; WBY is selected otherwise.
- Gated strobes, combinational from WSP inputs and registered active_op:
  - wbr_shift = shiftwr & ~capturewr & ~selectwir & wbr_sel.
  - wbr_capture = capturewr & ~selectwir & wbr_sel & (op != PRELOAD).
  - wbr_update = updatewr & ~selectwir & wbr_sel.
- WBY, when selectwir=0 and WBY is selected: capturewr -> 0; shiftwr -> wsi.
- Priority: capturewr beats shiftwr everywhere. Both high sets wsp_err, which clears only on reset.
- wso mux: selectwir ? wir_sr[0] : (wbr_sel ? wbr_so : wby).
- Instruction change mid-scan: selection follows active_op immediately on the cycle after update. No pipeline flush.
- arst_n assertion mid-shift returns all state to reset asynchronously. Release is synchronised externally.

Optional Feature:
- Macro WIR_CLAMP_EN.
- Defined: opcode 5 is WS_CLAMP, with wbr_mode=1, wbr_safe=0, and WBY selected.
- Undefined: opcode 5 decodes as WS_BYPASS, with wbr_mode=0.

Decomposition:
- Package wsp_pkg: IR_W default localparam, wir_op_e enum of opcodes, and a CAPTURE_VAL default.
- Sub-module wir_decoder: combinational op -> {wbr_sel, mode, safe, capture_ok}. It is instantiated once for the registered-decode path.

Test Plan:
- Reset: arst_n=0 mid-shift -> active_op=0, wso=0, wbr_mode=0, all strobes 0, wsp_err=0.
- Load EXTEST: selectwir=1, capturewr 1 cycle, then 3 shifts of wsi=1,0,0, then updatewr.
  - wso sequence during shifts is 1,0,0 (CAPTURE_VAL).
  - active_op=1 and wbr_mode=1 on the cycle after update.
- EXTEST data path: selectwir=0, capturewr, then shiftwr×4 -> wbr_capture pulses once and wbr_shift is high 4 cycles; wso tracks wbr_so.
- SAFE then BYPASS: load op 3 -> wbr_mode=1, wbr_safe=1. Data shift of wsi=1 -> wso=1 one cycle later via WBY; wbr_shift stays 0.
- PRELOAD: capturewr with selectwir=0 -> wbr_capture=0 and wbr_shift works; wbr_update fires on updatewr; wbr_mode=0.
- Conflict and clamp:
  - shiftwr=capturewr=1 -> capture wins and wsp_err=1 stays set.
  - Op 5 -> wbr_mode=1 with WIR_CLAMP_EN, and 0 without.
